// File: rtl/vai_pkg.sv
// Shared widths, request structs and helpers for the VAI TX auditor.
package vai_pkg;

    localparam int unsigned ADDR_W        = 42;
    localparam int unsigned MDATA_W       = 16;
    localparam int unsigned C0_HDR_REST_W = 32;
    localparam int unsigned C1_HDR_REST_W = 32;
    localparam int unsigned C1_DATA_W     = 512;
    localparam int unsigned CNT_W         = 16;

    typedef struct packed {
        logic [ADDR_W-1:0]        addr;
        logic [MDATA_W-1:0]       mdata;
        logic [C0_HDR_REST_W-1:0] hdr_rest;
    } t_vai_c0_req;

    typedef struct packed {
        logic [ADDR_W-1:0]        addr;
        logic [MDATA_W-1:0]       mdata;
        logic [C1_HDR_REST_W-1:0] hdr_rest;
        logic [C1_DATA_W-1:0]     data;
    } t_vai_c1_req;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vai_audit_chan.sv
// Single-channel 2-stage audit pipeline: relocate address, tag mdata with vmid,
// drop traffic from sub-AFUs in reset or whose relocation overflows.
module vai_audit_chan
    import vai_pkg::*;
#(
    parameter int unsigned NUM_SUB_AFUS = 8,
    parameter int unsigned VMID_W       = $clog2(NUM_SUB_AFUS),
    parameter int unsigned HDR_REST_W   = 32,
    parameter int unsigned DATA_W       = 0,
    localparam int unsigned DW          = (DATA_W > 0) ? DATA_W : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [64*NUM_SUB_AFUS-1:0] offset_flat,
    input  logic [NUM_SUB_AFUS-1:0]    sub_afu_reset,
    input  logic                       in_valid,
    input  logic [VMID_W-1:0]          in_vmid,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [MDATA_W-1:0]         in_mdata,
    input  logic [HDR_REST_W-1:0]      in_hdr_rest,
    input  logic [DW-1:0]              in_data,
    output logic                       out_valid,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [MDATA_W-1:0]         out_mdata,
    output logic [HDR_REST_W-1:0]      out_hdr_rest,
    output logic [DW-1:0]              out_data,
    output logic                       err_overflow,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int unsigned KEEP_W = MDATA_W - VMID_W;

    logic [63:0]       off;
    logic [ADDR_W:0]   sum;
    logic              ovf;

    logic              t1_valid_q;
    logic              t1_ovf_q;
    logic              t1_rst_q;
    logic [VMID_W-1:0] t1_vmid_q;
    logic [ADDR_W-1:0] t1_addr_q;
    logic [KEEP_W-1:0] t1_mdata_q;
    logic [HDR_REST_W-1:0] t1_hdr_q;

    logic drop;
    logic ovf_drop;
    logic unused_mdata_hi;

    assign off = offset_flat[{in_vmid, 6'd0} +: 64];
    assign sum = {1'b0, in_addr} + {1'b0, off[ADDR_W-1:0]};
    // Offset bits beyond the address width overflow for every address.
    assign ovf = sum[ADDR_W] | (|off[63:ADDR_W]);

    // Sub-AFU reset wins over overflow: such drops never raise the error flag.
    assign drop     = t1_valid_q & (t1_rst_q | t1_ovf_q);
    assign ovf_drop = t1_valid_q & t1_ovf_q & ~t1_rst_q;

    // Upper mdata bits are replaced by the vmid tag.
    assign unused_mdata_hi = ^in_mdata[MDATA_W-1 -: VMID_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            t1_valid_q   <= 1'b0;
            out_valid    <= 1'b0;
            err_overflow <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            t1_valid_q <= in_valid;
            out_valid  <= t1_valid_q & ~t1_ovf_q & ~t1_rst_q;
            if (ovf_drop) begin
                err_overflow <= 1'b1;
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        t1_ovf_q     <= ovf;
        t1_rst_q     <= sub_afu_reset[in_vmid];
        t1_vmid_q    <= in_vmid;
        t1_addr_q    <= sum[ADDR_W-1:0];
        t1_mdata_q   <= in_mdata[KEEP_W-1:0];
        t1_hdr_q     <= in_hdr_rest;
        out_addr     <= t1_addr_q;
        out_mdata    <= {t1_vmid_q, t1_mdata_q};
        out_hdr_rest <= t1_hdr_q;
    end

    if (DATA_W > 0) begin : g_data
        logic [DW-1:0] t1_data_q;
        always_ff @(posedge clk) begin
            t1_data_q <= in_data;
            out_data  <= t1_data_q;
        end
    end else begin : g_no_data
        logic unused_data;
        assign unused_data = ^in_data;
        assign out_data    = '0;
    end

endmodule

// File: rtl/vai_tx_auditor.sv
// Audits sub-AFU TX requests on c0 (read) and c1 (write) before they reach the manager.
module vai_tx_auditor
    import vai_pkg::*;
#(
    parameter int unsigned NUM_SUB_AFUS = 8,
    parameter int unsigned VMID_W       = $clog2(NUM_SUB_AFUS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [64*NUM_SUB_AFUS-1:0] offset_flat,
    input  logic [NUM_SUB_AFUS-1:0]    sub_afu_reset,
    input  logic                       in_c0_valid,
    input  logic [VMID_W-1:0]          in_c0_vmid,
    input  logic [ADDR_W-1:0]          in_c0_addr,
    input  logic [MDATA_W-1:0]         in_c0_mdata,
    input  logic [C0_HDR_REST_W-1:0]   in_c0_hdr_rest,
    input  logic                       in_c1_valid,
    input  logic [VMID_W-1:0]          in_c1_vmid,
    input  logic [ADDR_W-1:0]          in_c1_addr,
    input  logic [MDATA_W-1:0]         in_c1_mdata,
    input  logic [C1_HDR_REST_W-1:0]   in_c1_hdr_rest,
    input  logic [C1_DATA_W-1:0]       in_c1_data,
    output logic                       out_c0_valid,
    output logic [ADDR_W-1:0]          out_c0_addr,
    output logic [MDATA_W-1:0]         out_c0_mdata,
    output logic [C0_HDR_REST_W-1:0]   out_c0_hdr_rest,
    output logic                       out_c1_valid,
    output logic [ADDR_W-1:0]          out_c1_addr,
    output logic [MDATA_W-1:0]         out_c1_mdata,
    output logic [C1_HDR_REST_W-1:0]   out_c1_hdr_rest,
    output logic [C1_DATA_W-1:0]       out_c1_data,
    output logic                       err_c0_overflow,
    output logic                       err_c1_overflow,
    output logic [CNT_W-1:0]           drop_c0_cnt,
    output logic [CNT_W-1:0]           drop_c1_cnt
);

    t_vai_c0_req c0_req;
    t_vai_c1_req c1_req;
    logic [0:0]  c0_data_unused;

    assign c0_req = '{addr: in_c0_addr, mdata: in_c0_mdata, hdr_rest: in_c0_hdr_rest};
    assign c1_req = '{addr: in_c1_addr, mdata: in_c1_mdata, hdr_rest: in_c1_hdr_rest,
                      data: in_c1_data};

    vai_audit_chan #(
        .NUM_SUB_AFUS (NUM_SUB_AFUS),
        .VMID_W       (VMID_W),
        .HDR_REST_W   (C0_HDR_REST_W),
        .DATA_W       (0)
    ) u_c0 (
        .clk           (clk),
        .reset         (reset),
        .offset_flat   (offset_flat),
        .sub_afu_reset (sub_afu_reset),
        .in_valid      (in_c0_valid),
        .in_vmid       (in_c0_vmid),
        .in_addr       (c0_req.addr),
        .in_mdata      (c0_req.mdata),
        .in_hdr_rest   (c0_req.hdr_rest),
        .in_data       (1'b0),
        .out_valid     (out_c0_valid),
        .out_addr      (out_c0_addr),
        .out_mdata     (out_c0_mdata),
        .out_hdr_rest  (out_c0_hdr_rest),
        .out_data      (c0_data_unused),
        .err_overflow  (err_c0_overflow),
        .drop_cnt      (drop_c0_cnt)
    );

    vai_audit_chan #(
        .NUM_SUB_AFUS (NUM_SUB_AFUS),
        .VMID_W       (VMID_W),
        .HDR_REST_W   (C1_HDR_REST_W),
        .DATA_W       (C1_DATA_W)
    ) u_c1 (
        .clk           (clk),
        .reset         (reset),
        .offset_flat   (offset_flat),
        .sub_afu_reset (sub_afu_reset),
        .in_valid      (in_c1_valid),
        .in_vmid       (in_c1_vmid),
        .in_addr       (c1_req.addr),
        .in_mdata      (c1_req.mdata),
        .in_hdr_rest   (c1_req.hdr_rest),
        .in_data       (c1_req.data),
        .out_valid     (out_c1_valid),
        .out_addr      (out_c1_addr),
        .out_mdata     (out_c1_mdata),
        .out_hdr_rest  (out_c1_hdr_rest),
        .out_data      (out_c1_data),
        .err_overflow  (err_c1_overflow),
        .drop_cnt      (drop_c1_cnt)
    );

endmodule

// File: tb/tb_vai_tx_auditor.sv
// Directed bench for vai_tx_auditor: relocation, tagging, drops, saturation, streaming, reset.
module tb_vai_tx_auditor;
    import vai_pkg::*;

    localparam int unsigned N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [64*N-1:0] offset_flat;
    logic [N-1:0]   sub_afu_reset;
    logic           in_c0_valid, in_c1_valid;
    logic [2:0]     in_c0_vmid, in_c1_vmid;
    logic [41:0]    in_c0_addr, in_c1_addr;
    logic [15:0]    in_c0_mdata, in_c1_mdata;
    logic [31:0]    in_c0_hdr_rest, in_c1_hdr_rest;
    logic [511:0]   in_c1_data;
    logic           out_c0_valid, out_c1_valid;
    logic [41:0]    out_c0_addr, out_c1_addr;
    logic [15:0]    out_c0_mdata, out_c1_mdata;
    logic [31:0]    out_c0_hdr_rest, out_c1_hdr_rest;
    logic [511:0]   out_c1_data;
    logic           err_c0_overflow, err_c1_overflow;
    logic [15:0]    drop_c0_cnt, drop_c1_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vai_tx_auditor #(.NUM_SUB_AFUS(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .offset_flat     (offset_flat),
        .sub_afu_reset   (sub_afu_reset),
        .in_c0_valid     (in_c0_valid),
        .in_c0_vmid      (in_c0_vmid),
        .in_c0_addr      (in_c0_addr),
        .in_c0_mdata     (in_c0_mdata),
        .in_c0_hdr_rest  (in_c0_hdr_rest),
        .in_c1_valid     (in_c1_valid),
        .in_c1_vmid      (in_c1_vmid),
        .in_c1_addr      (in_c1_addr),
        .in_c1_mdata     (in_c1_mdata),
        .in_c1_hdr_rest  (in_c1_hdr_rest),
        .in_c1_data      (in_c1_data),
        .out_c0_valid    (out_c0_valid),
        .out_c0_addr     (out_c0_addr),
        .out_c0_mdata    (out_c0_mdata),
        .out_c0_hdr_rest (out_c0_hdr_rest),
        .out_c1_valid    (out_c1_valid),
        .out_c1_addr     (out_c1_addr),
        .out_c1_mdata    (out_c1_mdata),
        .out_c1_hdr_rest (out_c1_hdr_rest),
        .out_c1_data     (out_c1_data),
        .err_c0_overflow (err_c0_overflow),
        .err_c1_overflow (err_c1_overflow),
        .drop_c0_cnt     (drop_c0_cnt),
        .drop_c1_cnt     (drop_c1_cnt)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_c0_valid = 1'b0;
        in_c1_valid = 1'b0;
    endtask

    task automatic drive_c0(input logic [2:0] vmid, input logic [41:0] addr,
                            input logic [15:0] mdata, input logic [31:0] hdr);
        in_c0_valid = 1'b1; in_c0_vmid = vmid; in_c0_addr = addr;
        in_c0_mdata = mdata; in_c0_hdr_rest = hdr;
    endtask

    task automatic drive_c1(input logic [2:0] vmid, input logic [41:0] addr,
                            input logic [15:0] mdata, input logic [31:0] hdr,
                            input logic [511:0] data);
        in_c1_valid = 1'b1; in_c1_vmid = vmid; in_c1_addr = addr;
        in_c1_mdata = mdata; in_c1_hdr_rest = hdr; in_c1_data = data;
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    logic [89:0]  q0[$];
    logic [89:0]  q1[$];
    logic [511:0] qd[$];
    logic [511:0] data_b;

    initial begin
        int n0, n1;
        logic [63:0]  r;
        logic [2:0]   v;
        logic [41:0]  a;
        logic [15:0]  m;
        logic [31:0]  h;
        logic [511:0] d;

        reset = 1'b1; offset_flat = '0; sub_afu_reset = '0; idle();
        drive_c0(0, 0, 0, 0); drive_c1(0, 0, 0, 0, '0); idle();
        step(); step();
        check_eq("rst_c0_valid", out_c0_valid, 0);
        check_eq("rst_c1_valid", out_c1_valid, 0);
        check_eq("rst_err_c0", err_c0_overflow, 0);
        check_eq("rst_err_c1", err_c1_overflow, 0);
        check_eq("rst_drop_c0", drop_c0_cnt, 0);
        check_eq("rst_drop_c1", drop_c1_cnt, 0);
        reset = 1'b0; step();

        // Basic relocation and vmid tagging
        offset_flat[64*3 +: 64] = 64'h1000;
        drive_c0(3, 42'h20, 16'h0ABC, 32'hDEADBEEF); step(); idle();
        check_eq("c0_not_early", out_c0_valid, 0);
        step();
        check_eq("c0_valid", out_c0_valid, 1);
        check_eq("c0_addr", out_c0_addr, 42'h1020);
        check_eq("c0_mdata", out_c0_mdata, 16'h6ABC);
        check_eq("c0_hdr", out_c0_hdr_rest, 32'hDEADBEEF);
        step();
        check_eq("c0_single", out_c0_valid, 0);

        // Sub-AFU reset drop on c1, back-to-back with a good request
        sub_afu_reset = 8'h04; offset_flat[64*1 +: 64] = 64'h40;
        data_b = rnd512();
        drive_c1(2, 42'h100, 16'h1234, 32'h1, rnd512()); step();
        drive_c1(1, 42'h200, 16'hFFFF, 32'hCAFEF00D, data_b); step(); idle();
        check_eq("c1_rst_dropped", out_c1_valid, 0);
        step();
        check_eq("c1_v1_valid", out_c1_valid, 1);
        check_eq("c1_v1_addr", out_c1_addr, 42'h240);
        check_eq("c1_v1_mdata", out_c1_mdata, 16'h3FFF);
        check_eq("c1_v1_hdr", out_c1_hdr_rest, 32'hCAFEF00D);
        check_eq("c1_v1_data", out_c1_data, data_b);
        check_eq("c1_drop_cnt1", drop_c1_cnt, 1);
        check_eq("c1_no_err", err_c1_overflow, 0);
        sub_afu_reset = '0;

        // Carry-out overflow, sticky flag, then high-offset-bit overflow
        offset_flat[64*0 +: 64] = 64'h3FF_FFFF_FFFF;
        drive_c0(0, 42'h1, 16'h0, 32'h0); step(); idle(); step();
        check_eq("ovf_dropped", out_c0_valid, 0);
        check_eq("ovf_err", err_c0_overflow, 1);
        check_eq("ovf_cnt", drop_c0_cnt, 1);
        drive_c0(3, 42'h0, 16'h0001, 32'h5); step(); idle(); step();
        check_eq("post_ovf_valid", out_c0_valid, 1);
        check_eq("post_ovf_addr", out_c0_addr, 42'h1000);
        check_eq("err_sticky", err_c0_overflow, 1);
        offset_flat[64*5 +: 64] = 64'h0000_0400_0000_0000;
        drive_c0(5, 42'h0, 16'h0, 32'h0); step(); idle(); step();
        check_eq("hi_off_dropped", out_c0_valid, 0);
        check_eq("hi_off_cnt", drop_c0_cnt, 2);

        // Reset beats overflow: no error flag
        sub_afu_reset = 8'h01;
        drive_c1(0, 42'h1, 16'h0, 32'h0, '0); step(); idle(); step();
        check_eq("prec_dropped", out_c1_valid, 0);
        check_eq("prec_no_err", err_c1_overflow, 0);
        check_eq("prec_cnt", drop_c1_cnt, 2);

        // Saturation
        sub_afu_reset = 8'h04;
        drive_c0(2, 42'h0, 16'h0, 32'h0);
        repeat (70000) step();
        idle(); step(); step();
        check_eq("sat_c0", drop_c0_cnt, 16'hFFFF);
        check_eq("sat_c1_indep", drop_c1_cnt, 2);
        sub_afu_reset = '0;

        // Sustained streaming on both channels
        offset_flat = '0;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 102; i++) begin
            if (i < 100) begin
                v = 3'($urandom_range(0, 7)); r = {$urandom, $urandom};
                a = r[41:0]; m = r[63:48]; h = $urandom;
                drive_c0(v, a, m, h);
                q0.push_back({a, v, m[12:0], h});
                v = 3'($urandom_range(0, 7)); r = {$urandom, $urandom};
                a = r[41:0]; m = r[63:48]; h = $urandom; d = rnd512();
                drive_c1(v, a, m, h, d);
                q1.push_back({a, v, m[12:0], h});
                qd.push_back(d);
            end else begin
                idle();
            end
            step();
            check_eq("stream_c0_valid", out_c0_valid, (i >= 1 && i <= 100));
            check_eq("stream_c1_valid", out_c1_valid, (i >= 1 && i <= 100));
            if (out_c0_valid && q0.size() > 0) begin
                n0++;
                check_eq("stream_c0", {out_c0_addr, out_c0_mdata, out_c0_hdr_rest},
                         q0.pop_front());
            end
            if (out_c1_valid && q1.size() > 0) begin
                n1++;
                check_eq("stream_c1", {out_c1_addr, out_c1_mdata, out_c1_hdr_rest},
                         q1.pop_front());
                check_eq("stream_c1_data", out_c1_data, qd.pop_front());
            end
        end
        check_eq("stream_c0_count", n0, 100);
        check_eq("stream_c1_count", n1, 100);

        // Reset with both stages loaded; inputs stay valid across the reset edge
        drive_c0(3, 42'h5, 16'h0, 32'h0); drive_c1(1, 42'h6, 16'h0, 32'h0, '0); step();
        drive_c0(4, 42'h7, 16'h0, 32'h0); drive_c1(2, 42'h8, 16'h0, 32'h0, '0); step();
        reset = 1'b1; step();
        check_eq("mid_rst_c0_valid", out_c0_valid, 0);
        check_eq("mid_rst_c1_valid", out_c1_valid, 0);
        reset = 1'b0; idle(); step();
        check_eq("post_rst_c0_valid", out_c0_valid, 0);
        check_eq("post_rst_c1_valid", out_c1_valid, 0);
        check_eq("post_rst_err_c0", err_c0_overflow, 0);
        check_eq("post_rst_err_c1", err_c1_overflow, 0);
        check_eq("post_rst_cnt_c0", drop_c0_cnt, 0);
        check_eq("post_rst_cnt_c1", drop_c1_cnt, 0);
        step();
        check_eq("post_rst2_c0_valid", out_c0_valid, 0);
        check_eq("post_rst2_c1_valid", out_c1_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vai_tx_auditor.md
Name: vai_tx_auditor

Overview:
- Sits between the sub-AFU mux TX output and the manager's AFU-side TX input.
- Each cycle, audits every c0 (read) and c1 (write) request from a sub-AFU:
  - relocates the cache-line address by that sub-AFU's offset register;
  - tags mdata with the originating vmid;
  - drops requests from sub-AFUs held in reset or whose relocated address overflows.
- Fixed 2-cycle latency, no backpressure of its own. Almost-full is handled upstream; the manager's side-buffer sizing already covers these 2 stages.

Parameters:
- NUM_SUB_AFUS, 8, number of sub-AFUs; power of 2, 2..64.
- VMID_W, $clog2(NUM_SUB_AFUS), vmid width.
- ADDR_W, 42, CCI-P cache-line address width.
- MDATA_W, 16, request mdata width.
- C0_HDR_REST_W, 32, remaining c0 header bits, passed through untouched.
- C1_HDR_REST_W, 32, remaining c1 header bits, passed through untouched.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- offset_flat  in  64*NUM_SUB_AFUS  per-vmid offsets, vmid i at [64i+63:64i]
- sub_afu_reset  in  NUM_SUB_AFUS  bit i high = drop vmid i traffic
- in_c0_valid  in  1  read request valid
- in_c0_vmid  in  VMID_W  originating sub-AFU
- in_c0_addr  in  ADDR_W  sub-AFU-relative address
- in_c0_mdata  in  MDATA_W  sub-AFU mdata
- in_c0_hdr_rest  in  C0_HDR_REST_W  other header fields
- in_c1_valid  in  1  write request valid
- in_c1_vmid / in_c1_addr / in_c1_mdata / in_c1_hdr_rest  in  same widths as c0
- in_c1_data  in  512  write data
- out_c0_valid  out  1
- out_c0_addr / out_c0_mdata / out_c0_hdr_rest  out  same widths as inputs
- out_c1_valid  out  1
- out_c1_addr / out_c1_mdata / out_c1_hdr_rest / out_c1_data  out  same widths as inputs
- err_c0_overflow, err_c1_overflow  out  1  sticky relocation-overflow flags
- drop_c0_cnt, drop_c1_cnt  out  16  saturating dropped-request counters

Behaviour:
- Reset values: all out_*_valid=0, err flags=0, drop counters=0. Payload outputs are don't-care while valid=0. Reset mid-operation discards both pipeline stages; no request in flight emerges after reset.
- Channels c0 and c1 are fully independent and identical; c1 additionally carries data.
- Stage T1 (registered):
  - capture input fields;
  - select off = offset_flat slice for vmid;
  - compute sum = {1'b0,addr} + {1'b0,off[ADDR_W-1:0]};
  - ovf = sum[ADDR_W] | (off[63:ADDR_W] != 0);
  - rst = sub_afu_reset[vmid], sampled at T0.
- Stage T2 (registered output):
  - out_valid = T1_valid & ~T1_ovf & ~T1_rst;
  - out_addr = sum[ADDR_W-1:0];
  - out_mdata = {T1_vmid, T1_mdata[MDATA_W-VMID_W-1:0]}; the upper VMID_W bits of the sub-AFU mdata are overwritten;
  - hdr_rest and data pass through unchanged.
- Latency: request valid at cycle N appears at the output at cycle N+2. One request per channel per cycle sustained; no bubbles.
- Drop rules:
  - T1_valid & T1_rst → drop, no error flag, counter +1.
  - T1_valid & T1_ovf & ~T1_rst → drop, err_*_overflow set (sticky until reset), counter +1.
  - Reset takes precedence over overflow.
- Counters saturate at 16'hFFFF and never wrap. A c0 drop and a c1 drop in the same cycle update their own counters independently.
- offset_flat or sub_afu_reset changing mid-stream: sampled when the request enters T1. Requests already in T1 keep their old offset.
- Offset with bits above ADDR_W set is an overflow for every address, including addr=0.
- Offset arithmetic is unsigned add only; negative relocation is unsupported.

Decomposition:
- Package vai_pkg holds: ADDR_W, MDATA_W, header-rest widths, the t_vai_c0_req / t_vai_c1_req packed structs, and a saturating-increment function.
- One sub-module, vai_audit_chan: the parameterised single-channel 2-stage pipeline with data width as a parameter (0 for c0, 512 for c1). The top instantiates it twice.

Test Plan:
- offset[3]=64'h1000; c0 request vmid=3, addr=42'h20, mdata=16'h0ABC → two cycles later out_c0_valid=1, addr=42'h1020, mdata={3'd3,13'h0ABC}=16'h6ABC.
- sub_afu_reset=8'h04; c1 requests back-to-back from vmid 2 and vmid 1 → only vmid 1 emerges, at N+3; drop_c1_cnt=1; err_c1_overflow=0.
- offset[0]=64'h3FF_FFFF_FFFF (all ADDR_W ones); c0 addr=1 → dropped; err_c0_overflow=1 and stays 1 for later good traffic. Separately, offset[5]=64'h1<<42 with addr=0 → dropped.
- 70000 consecutive dropped c0 requests → drop_c0_cnt holds at 16'hFFFF.
- Continuous valid on both channels for 100 cycles with random vmids and zero offsets → 100 outputs per channel, in order, with data intact.
- Reset asserted with requests in T1 and T2 → no out valid in the cycle after reset releases; counters and flags are 0.
